// File: rtl/ifid_reg_pkg.sv
// Shared control-encoding constants (ctrl_encode_def) and the IF/ID entry type (ifid_reg_pkg).
// ctrl_encode_def: reset PC, NOP encoding, RISC-V immediate field bit positions.
// ifid_reg_pkg: packed storage entry used by the IF/ID register.
package ctrl_encode_def;
  localparam logic [31:0] PC_RESET   = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP  = 32'h0000_0013;  // addi x0,x0,0

  // I-type shift amount and immediate
  localparam int SHAMT_HI    = 24;
  localparam int SHAMT_LO    = 20;
  localparam int IIMM_HI     = 31;
  localparam int IIMM_LO     = 20;
  // S-type immediate, upper and lower parts
  localparam int SIMM_UP_HI  = 31;
  localparam int SIMM_UP_LO  = 25;
  localparam int SIMM_DN_HI  = 11;
  localparam int SIMM_DN_LO  = 7;
  // B-type immediate, scrambled across the word
  localparam int BIMM_SIGN   = 31;
  localparam int BIMM_B11    = 7;
  localparam int BIMM_MID_HI = 30;
  localparam int BIMM_MID_LO = 25;
  localparam int BIMM_LOW_HI = 11;
  localparam int BIMM_LOW_LO = 8;
  // U-type immediate
  localparam int UIMM_HI     = 31;
  localparam int UIMM_LO     = 12;
  // J-type immediate, scrambled across the word
  localparam int JIMM_SIGN   = 31;
  localparam int JIMM_UP_HI  = 19;
  localparam int JIMM_UP_LO  = 12;
  localparam int JIMM_B11    = 20;
  localparam int JIMM_LOW_HI = 30;
  localparam int JIMM_LOW_LO = 21;
  // CSR zero-extended immediate (rs1 field)
  localparam int ZIMM_HI     = 19;
  localparam int ZIMM_LO     = 15;
endpackage

package ifid_reg_pkg;
  typedef struct packed {
    logic        vld;
    logic [31:0] pc;
    logic [31:0] instr;
  } ifid_entry_t;
endpackage

// File: rtl/ifid_reg_if.sv
// IF/ID handshake bundle: fetch-side beat in, decode-side beat out, flush, immediate fields.
// Latency: none (wires only).
// Backpressure: in_ready/out_ready valid-ready pairs carried as plain members.
// Modports: slave = the IF/ID register's view, master = the driver/consumer view.
interface ifid_reg_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [4:0]  out_iimm_shamt;
  logic [11:0] out_iimm;
  logic [11:0] out_simm;
  logic [11:0] out_bimm;
  logic [19:0] out_uimm;
  logic [19:0] out_jimm;
  logic [4:0]  out_zimm;

  modport slave (
    input  in_valid, in_pc, in_instr, flush, out_ready,
    output in_ready, out_valid, out_pc, out_instr,
    output out_iimm_shamt, out_iimm, out_simm, out_bimm, out_uimm, out_jimm, out_zimm
  );

  modport master (
    output in_valid, in_pc, in_instr, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_instr,
    input  out_iimm_shamt, out_iimm, out_simm, out_bimm, out_uimm, out_jimm, out_zimm
  );
endinterface

// File: rtl/ifid_reg_instr_fields.sv
// Slices the RISC-V immediate fields out of an instruction word (raw, not sign-extended).
// Latency: purely combinational.
// Backpressure: none.
// Ports: instr_i word in; *_o raw immediate fields out.
module instr_fields
  import ctrl_encode_def::*;
(
  input  logic [31:0] instr_i,
  output logic [4:0]  iimm_shamt_o,
  output logic [11:0] iimm_o,
  output logic [11:0] simm_o,
  output logic [11:0] bimm_o,
  output logic [19:0] uimm_o,
  output logic [19:0] jimm_o,
  output logic [4:0]  zimm_o
);
  assign iimm_shamt_o = instr_i[SHAMT_HI:SHAMT_LO];
  assign iimm_o       = instr_i[IIMM_HI:IIMM_LO];
  assign simm_o       = {instr_i[SIMM_UP_HI:SIMM_UP_LO], instr_i[SIMM_DN_HI:SIMM_DN_LO]};
  assign bimm_o       = {instr_i[BIMM_SIGN], instr_i[BIMM_B11],
                         instr_i[BIMM_MID_HI:BIMM_MID_LO], instr_i[BIMM_LOW_HI:BIMM_LOW_LO]};
  assign uimm_o       = instr_i[UIMM_HI:UIMM_LO];
  assign jimm_o       = {instr_i[JIMM_SIGN], instr_i[JIMM_UP_HI:JIMM_UP_LO],
                         instr_i[JIMM_B11], instr_i[JIMM_LOW_HI:JIMM_LOW_LO]};
  assign zimm_o       = instr_i[ZIMM_HI:ZIMM_LO];
endmodule

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: holds fetched beats for decode and exposes their immediate fields.
// Latency: 1 cycle from in_* acceptance to out_*; flush empties the register at the same edge.
// Backpressure: IFID_SKID_EN defined -> main+skid entries, in_ready registered (!skid full);
//               IFID_SKID_EN undefined -> single entry, in_ready = !out_valid || out_ready.
// Ports: clk, rstn (async active-low), bus (ifid_reg_if.slave).
module ifid_reg
  import ctrl_encode_def::*;
  import ifid_reg_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = PC_RESET,
  parameter logic [31:0] NOP_INSTR = INSTR_NOP
) (
  input  logic       clk,
  input  logic       rstn,
  ifid_reg_if.slave  bus
);
  ifid_entry_t main_q, main_d;
  ifid_entry_t in_beat;
  logic        in_rdy;
  logic        accept;
  logic        deq;
  logic [31:0] out_instr;

  assign in_beat = '{vld: 1'b1, pc: bus.in_pc, instr: bus.in_instr};
  assign accept  = bus.in_valid && in_rdy;
  assign deq     = main_q.vld && bus.out_ready;

`ifdef IFID_SKID_EN
  ifid_entry_t skid_q, skid_d;

  // Registered ready: the skid slot absorbs the one beat that can arrive
  // while decode stalls, so ready never depends on out_ready this cycle.
  assign in_rdy = !skid_q.vld;

  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (bus.flush) begin
      main_d.vld = 1'b0;
      skid_d.vld = 1'b0;
    end else if (deq) begin
      if (skid_q.vld) begin
        // in_ready was low, so no beat can be accepted alongside this move
        main_d     = skid_q;
        skid_d.vld = 1'b0;
      end else if (accept) begin
        main_d = in_beat;
      end else begin
        main_d.vld = 1'b0;
      end
    end else if (accept) begin
      if (main_q.vld) skid_d = in_beat;
      else            main_d = in_beat;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) skid_q <= '0;
    else       skid_q <= skid_d;
  end
`else
  assign in_rdy = !main_q.vld || bus.out_ready;

  always_comb begin
    main_d = main_q;
    if (bus.flush)   main_d.vld = 1'b0;
    else if (accept) main_d     = in_beat;
    else if (deq)    main_d.vld = 1'b0;
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) main_q <= '0;
    else       main_q <= main_d;
  end

  // An empty register presents a NOP at the reset PC so decode sees a bubble.
  assign out_instr     = main_q.vld ? main_q.instr : NOP_INSTR;
  assign bus.out_instr = out_instr;
  assign bus.out_pc    = main_q.vld ? main_q.pc : RESET_PC;
  assign bus.out_valid = main_q.vld;
  assign bus.in_ready  = in_rdy;

  instr_fields u_fields (
    .instr_i      (out_instr),
    .iimm_shamt_o (bus.out_iimm_shamt),
    .iimm_o       (bus.out_iimm),
    .simm_o       (bus.out_simm),
    .bimm_o       (bus.out_bimm),
    .uimm_o       (bus.out_uimm),
    .jimm_o       (bus.out_jimm),
    .zimm_o       (bus.out_zimm)
  );
endmodule

// File: tb/tb_ifid_reg.sv
// Directed bench for ifid_reg: reset, streaming, backpressure, flush and immediate fields.
// Covers both builds; the skid-specific sequences are selected by IFID_SKID_EN.
module tb_ifid_reg;
  logic clk;
  logic rstn;
  int   checks;
  int   failures;

  localparam logic [31:0] I0 = 32'h0010_0093;
  localparam logic [31:0] I1 = 32'h0020_0113;
  localparam logic [31:0] I2 = 32'h0030_0193;

  ifid_reg_if bus ();

  ifid_reg dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic ordy, input logic fl);
    bus.in_valid  = v;
    bus.in_pc     = pc;
    bus.in_instr  = ins;
    bus.out_ready = ordy;
    bus.flush     = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [31:0] pc,
                            input logic [31:0] ins);
    check({tag, ".vld"},   {31'd0, bus.out_valid}, {31'd0, v});
    check({tag, ".pc"},    bus.out_pc, pc);
    check({tag, ".instr"}, bus.out_instr, ins);
  endtask

  task automatic expect_empty(input string tag);
    expect_out(tag, 1'b0, 32'h0000_0000, 32'h0000_0013);
    check({tag, ".rdy"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rstn     = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    tick();
    expect_empty("reset");

    // Release away from the edge with no beat offered: nothing is captured.
    rstn = 1'b1;
    tick();
    expect_empty("post_reset");

    // Streaming: each beat appears the cycle after acceptance, no bubbles.
    drive(1'b1, 32'h0, I0, 1'b1, 1'b0); tick(); expect_out("s0", 1'b1, 32'h0, I0);
    drive(1'b1, 32'h4, I1, 1'b1, 1'b0); tick(); expect_out("s1", 1'b1, 32'h4, I1);
    drive(1'b1, 32'h8, I2, 1'b1, 1'b0); tick(); expect_out("s2", 1'b1, 32'h8, I2);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0); tick(); expect_empty("s_end");

    // Backpressure with 0x0 held while 0x4 then 0x8 are offered.
    drive(1'b1, 32'h0, I0, 1'b1, 1'b0); tick(); expect_out("b0", 1'b1, 32'h0, I0);
`ifdef IFID_SKID_EN
    drive(1'b1, 32'h4, I1, 1'b0, 1'b0);
    check("b_rdy_skid_free", {31'd0, bus.in_ready}, 32'd1);
    tick();
    expect_out("b_hold1", 1'b1, 32'h0, I0);
    check("b_rdy_skid_full", {31'd0, bus.in_ready}, 32'd0);
    drive(1'b1, 32'h8, I2, 1'b0, 1'b0); tick();
    expect_out("b_hold2", 1'b1, 32'h0, I0);
    check("b_rdy_stall", {31'd0, bus.in_ready}, 32'd0);
    // 0x8 still offered but not accepted; skid moves to main.
    drive(1'b1, 32'h8, I2, 1'b1, 1'b0); tick();
    expect_out("b1", 1'b1, 32'h4, I1);
    check("b_rdy_drained", {31'd0, bus.in_ready}, 32'd1);
    drive(1'b1, 32'h8, I2, 1'b1, 1'b0); tick();
    expect_out("b2", 1'b1, 32'h8, I2);
`else
    drive(1'b1, 32'h4, I1, 1'b0, 1'b0);
    check("b_rdy_follow0", {31'd0, bus.in_ready}, 32'd0);
    tick();
    expect_out("b_hold1", 1'b1, 32'h0, I0);
    drive(1'b1, 32'h4, I1, 1'b1, 1'b0);
    check("b_rdy_follow1", {31'd0, bus.in_ready}, 32'd1);
    tick();
    expect_out("b1", 1'b1, 32'h4, I1);
    drive(1'b1, 32'h8, I2, 1'b1, 1'b0); tick();
    expect_out("b2", 1'b1, 32'h8, I2);
`endif
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0); tick(); expect_empty("b_end");

    // Flush discards held beats and the beat offered in the same cycle.
    drive(1'b1, 32'h10, I0, 1'b1, 1'b0); tick(); expect_out("f0", 1'b1, 32'h10, I0);
`ifdef IFID_SKID_EN
    drive(1'b1, 32'h14, I1, 1'b0, 1'b0); tick();
    check("f_skid_full", {31'd0, bus.in_ready}, 32'd0);
`endif
    drive(1'b1, 32'h18, I2, 1'b0, 1'b1); tick(); expect_empty("f_flushed");
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0); tick(); expect_empty("f_gone1");
    tick(); expect_empty("f_gone2");
    drive(1'b1, 32'h20, I1, 1'b1, 1'b0); tick(); expect_out("f_next", 1'b1, 32'h20, I1);

    // Immediate fields of the head beat.
    drive(1'b1, 32'h40, 32'hFE00_08E3, 1'b1, 1'b0); tick();
    check("bimm", {20'd0, bus.out_bimm}, 32'h0000_0FF8);
    check("simm", {20'd0, bus.out_simm}, 32'h0000_0FF1);
    check("iimm", {20'd0, bus.out_iimm}, 32'h0000_0FE0);
    check("uimm_b", {12'd0, bus.out_uimm}, 32'h000F_E000);
    check("jimm_b", {12'd0, bus.out_jimm}, 32'h0008_03F0);
    drive(1'b1, 32'h44, 32'hFF5F_F0EF, 1'b1, 1'b0); tick();
    check("jimm", {12'd0, bus.out_jimm}, 32'h000F_FFFA);
    check("zimm", {27'd0, bus.out_zimm}, 32'h0000_001F);
    check("shamt", {27'd0, bus.out_iimm_shamt}, 32'h0000_0015);
    check("uimm_j", {12'd0, bus.out_uimm}, 32'h000F_F5FF);

    // Reset asserted mid-stream acts immediately and discards everything.
    drive(1'b1, 32'h50, I0, 1'b1, 1'b0); tick();
`ifdef IFID_SKID_EN
    drive(1'b1, 32'h54, I1, 1'b0, 1'b0); tick();
    check("r_pre_skid", {31'd0, bus.in_ready}, 32'd0);
`endif
    expect_out("r_pre", 1'b1, 32'h50, I0);
    #2;
    rstn = 1'b0;
    #1;
    expect_empty("r_async");
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    rstn = 1'b1;
    tick();
    expect_empty("r_release");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ifid_reg.md
IFID_REG -- requirements
Module: ifid_reg

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the out_pc value held while empty and after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), meaning the out_instr value held while empty and after reset.
REQ-003 SHALL have port clk  input  1  the single clock, rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  fetch beat present.
REQ-006 SHALL have port in_ready  output  1  block can accept a beat.
REQ-007 SHALL have port in_pc  input  32  PC of the fetched instruction.
REQ-008 SHALL have port in_instr  input  32  fetched instruction word.
REQ-009 SHALL have port flush  input  1  discard all held and incoming beats (taken branch/jump).
REQ-010 SHALL have port out_valid  output  1  decode beat present.
REQ-011 SHALL have port out_ready  input  1  decode stage consumes the beat.
REQ-012 SHALL have port out_pc  output  32  PC of the head beat.
REQ-013 SHALL have port out_instr  output  32  instruction word of the head beat.
REQ-014 SHALL have immediate-field ports out_iimm_shamt (5), out_iimm (12), out_simm (12), out_bimm (12), out_uimm (20), out_jimm (20) and out_zimm (5), all outputs, feeding the immediate extender.

Function
REQ-015 SHALL transfer a beat in when in_valid && in_ready, and out when out_valid && out_ready, both at the rising clk edge.
REQ-016 SHALL preserve beat order, never duplicate a beat, and never drop a beat except on flush.
REQ-017 SHALL take the immediate fields combinationally from out_instr: iimm_shamt=[24:20], iimm=[31:20], simm={[31:25],[11:7]}, bimm={[31],[7],[30:25],[11:8]}, uimm=[31:12], jimm={[31],[19:12],[20],[30:21]}, zimm=[19:15].
REQ-018 SHALL hold two entries, main and skid; a beat arriving while empty, or while the head is leaving, SHALL appear on out_* in the next cycle (latency 1).
REQ-019 SHALL take in_ready from a register (no combinational path from out_ready): in_ready=1 whenever the skid entry is empty.
REQ-020 SHALL, when the main entry is held (out_valid && !out_ready) and a beat is accepted, place that beat in the skid entry; the next cycle in_ready=0.
REQ-021 SHALL, when the head leaves while the skid entry is full, move the skid entry to main; in_ready=1 next cycle.
REQ-022 SHALL handle a simultaneous in and out transfer with the skid entry empty as a direct replace of main (occupancy unchanged).
REQ-023 SHALL, on flush, clear both entries at that edge and ignore any beat presented in the same cycle; the next cycle has out_valid=0, in_ready=1 and out_pc/out_instr at RESET_PC/NOP_INSTR.
REQ-024 SHALL drive out_pc=RESET_PC and out_instr=NOP_INSTR whenever out_valid=0, so the downstream fields decode as a NOP.

Reset
REQ-025 SHALL, while rstn=0, asynchronously force out_valid=0, in_ready=1, skid entry empty, out_pc=RESET_PC and out_instr=NOP_INSTR; reset mid-transfer discards all beats.
REQ-026 SHALL not accept a beat at the first rising edge after rstn is deasserted unless in_valid=1 at that edge.

Configuration
REQ-027 SHALL use macro IFID_SKID_EN; when it is defined, the behaviour is the two-entry design of REQ-018..REQ-022.
REQ-028 SHALL, when IFID_SKID_EN is undefined, be a single-entry register with in_ready = !out_valid || out_ready (combinational); all other requirements are unchanged.

Structure
REQ-029 SHALL take NOP_INSTR, RESET_PC and the immediate field bit positions from the shared ctrl_encode_def definitions, not from local literals.
REQ-030 SHALL place the field slicing in sub-module instr_fields (pure combinational), reused by later stages; the storage stays in ifid_reg.

Verification
REQ-031 SHALL check reset: rstn=0 mid-stream -> out_valid=0, out_instr=32'h0000_0013, in_ready=1 immediately.
REQ-032 SHALL check streaming: beats pc=0x0/0x4/0x8 with out_ready=1 -> appear in order, one cycle later each, no bubbles.
REQ-033 SHALL check the skid path: out_ready=0 while pc=0x4 and then pc=0x8 are offered -> 0x4 held in skid, in_ready=0, 0x8 stalled; on out_ready=1 the beats appear as 0x0, 0x4, 0x8.
REQ-034 SHALL check flush: flush=1 with skid full and in_valid=1 -> next cycle out_valid=0 and in_ready=1, and the flushed beats never appear.
REQ-035 SHALL check fields: instr=32'hFE0008E3 (beq x0,x0,-16) -> out_bimm=12'hFF8; instr=32'hFF5FF0EF (jal x1,-12) -> out_jimm=20'hFFFFA.
REQ-036 SHALL rerun the streaming and flush checks with IFID_SKID_EN undefined -> identical beat order; in_ready follows out_ready in the same cycle.
